// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its downstream result decimator.
//   FIR_SAMPLE_W : filter input sample width
//   FIR_RESULT_W : filter result width (decimator data width)
//   fir_state_e  : decimator warm-up/run state
package fir_pkg;
    localparam int FIR_SAMPLE_W = 3;
    localparam int FIR_RESULT_W = 10;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fir_state_e;
endpackage

// File: rtl/fir_result_decimator_if.sv
// Handshake bundle between the filter-side producer / consumer and the decimator.
//   i_en, result : capture enable and filter result (into decimator)
//   o_data, o_valid, i_ready : FIFO head with valid/ready handshake
//   o_count, o_overflow : occupancy and sticky drop flag
interface fir_result_decimator_if
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_RESULT_W,
    parameter int DEPTH  = 8
);
    logic                     i_en;
    logic [DATA_W-1:0]        result;
    logic [DATA_W-1:0]        o_data;
    logic                     o_valid;
    logic                     i_ready;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_overflow;

    modport slave  (input i_en, result, i_ready,
                    output o_data, o_valid, o_count, o_overflow);
    modport master (output i_en, result, i_ready,
                    input o_data, o_valid, o_count, o_overflow);
endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO holding kept filter results.
//   push/din : write din (caller guarantees not full, or full with pop)
//   pop      : advance head (caller guarantees not empty)
//   dout     : head word, registered storage only
//   count    : occupancy 0..DEPTH; full/empty derived from it
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_RESULT_W,
    parameter int DEPTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Full with push+pop writes the slot being read this cycle; the old
    // word is still on dout until the edge, so ordering is preserved.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
endmodule

// File: rtl/fir_result_decimator.sv
// Decimates fir_filter results: drops SKIP enabled cycles of warm-up, then
// keeps one result of every DECIM enabled cycles into a FIFO read over a
// valid/ready handshake. o_overflow is sticky once a kept result is lost.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : i_en/result capture side, o_data/o_valid/i_ready head,
//                    o_count occupancy, o_overflow sticky drop flag
module fir_result_decimator
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_RESULT_W,
    parameter int DECIM  = 4,
    parameter int SKIP   = 8,
    parameter int DEPTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fir_result_decimator_if.slave bus
);
    localparam int SKW = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
    localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [SKW-1:0] SKIP_C     = SKW'(SKIP);
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(DECIM - 1);
    localparam fir_state_e     RST_STATE  = (SKIP == 0) ? RUN : WARMUP;

    fir_state_e     state_q, state_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic           overflow_q, overflow_d;
    logic           keep, push, pop, full, empty;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        phase_d    = phase_q;
        keep       = 1'b0;
        case (state_q)
            WARMUP: if (bus.i_en) begin
                skip_cnt_d = skip_cnt_q + 1'b1;
                if (skip_cnt_d == SKIP_C) state_d = RUN;
            end
            RUN: if (bus.i_en) begin
                keep    = (phase_q == '0);
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            end
        endcase
    end

    // Pop qualifies on o_valid (registered), so i_ready never reaches outputs.
    always_comb begin
        pop        = bus.o_valid && bus.i_ready;
        push       = keep && (!full || pop);
        overflow_d = overflow_q | (keep && full && !pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RST_STATE;
            skip_cnt_q <= '0;
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .push   (push),
        .pop    (pop),
        .din    (bus.result),
        .dout   (bus.o_data),
        .count  (bus.o_count),
        .full   (full),
        .empty  (empty)
    );

    assign bus.o_valid    = !empty;
    assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_fir_result_decimator.sv
module tb_fir_result_decimator;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n [N];
    logic       en    [N];
    logic [9:0] res   [N];
    logic       rdy   [N];
    logic       ov    [N];
    logic [9:0] od    [N];
    logic [3:0] oc    [N];
    logic       ovf   [N];

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: enabled-cycle count, list of buffered words, sticky flag.
    int n_en [N];
    int mc   [N];
    int mq   [N][16];
    bit mov  [N];

    always #5 clk = ~clk;

    // Instance configs: 0:(DECIM 4,SKIP 8) 1:(2,0) 2:(1,0) 3:(3,0); DEPTH 8.
    function automatic int mdec(input int id);
        return (id == 0) ? 4 : (id == 1) ? 2 : (id == 2) ? 1 : 3;
    endfunction
    function automatic int mskip(input int id);
        return (id == 0) ? 8 : 0;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        fir_result_decimator_if #(.DATA_W(10), .DEPTH(8)) ifc ();
        assign ifc.i_en    = en[g];
        assign ifc.result  = res[g];
        assign ifc.i_ready = rdy[g];
        assign ov[g]  = ifc.o_valid;
        assign od[g]  = ifc.o_data;
        assign oc[g]  = ifc.o_count;
        assign ovf[g] = ifc.o_overflow;
        fir_result_decimator #(
            .DATA_W(10), .DECIM(mdec(g)), .SKIP(mskip(g)), .DEPTH(8)
        ) u_dut (
            .i_clk  (clk),
            .i_rst_n(rst_n[g]),
            .bus    (ifc)
        );
    end

    task automatic model_reset(input int id);
        n_en[id] = 0;
        mc[id]   = 0;
        mov[id]  = 0;
    endtask

    // Advance one clock for instance id, updating the model from the inputs
    // present at the edge; returns 1 ns after the edge.
    task automatic tick(input int id);
        bit pop, keep, full;
        pop  = (mc[id] > 0) && (rdy[id] === 1'b1);
        keep = 0;
        if (en[id] === 1'b1) begin
            n_en[id]++;
            keep = (n_en[id] > mskip(id)) && (((n_en[id] - mskip(id) - 1) % mdec(id)) == 0);
        end
        full = (mc[id] == 8);
        if (pop) begin
            for (int i = 0; i < 15; i++) mq[id][i] = mq[id][i+1];
            mc[id]--;
        end
        if (keep && (!full || pop)) begin
            mq[id][mc[id]] = int'(res[id]);
            mc[id]++;
        end else if (keep) begin
            mov[id] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int id);
        rst_n[id] = 1'b0;
        en[id]    = 1'b0;
        rdy[id]   = 1'b0;
        res[id]   = '0;
        model_reset(id);
        @(posedge clk);
        #1;
        rst_n[id] = 1'b1;
    endtask

    task automatic test_reset();
        for (int id = 0; id < N; id++) begin
            n_cmp++;
            if (ov[id] !== 1'b0 || oc[id] !== 4'd0 || ovf[id] !== 1'b0 || od[id] !== 10'd0) begin
                n_fail++;
                $display("FAIL reset id=%0d valid=%b count=%0d ovf=%b data=%0d expected all 0",
                         id, ov[id], oc[id], ovf[id], od[id]);
            end
        end
        for (int id = 0; id < N; id++) do_reset(id);
    endtask

    task automatic test_warmup();
        int words [$];
        do_reset(0);
        en[0]  = 1'b1;
        rdy[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            res[0] = 10'(k);
            if (ov[0] === 1'b1) words.push_back(int'(od[0]));
            tick(0);
            n_cmp++;
            if (ov[0] !== (mc[0] > 0) || oc[0] !== 4'(mc[0]) || (mc[0] > 0 && od[0] !== 10'(mq[0][0]))) begin
                n_fail++;
                $display("FAIL warmup edge=%0d valid=%b count=%0d data=%0d expected valid=%b count=%0d data=%0d",
                         k, ov[0], oc[0], od[0], mc[0] > 0, mc[0], mq[0][0]);
            end
            if (k <= 8) begin
                n_cmp++;
                if (ov[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL warmup_quiet edge=%0d valid=%b expected 0", k, ov[0]);
                end
            end
        end
        n_cmp++;
        if (words.size() < 3 || words[0] != 9 || words[1] != 13 || words[2] != 17) begin
            n_fail++;
            $display("FAIL warmup_words got %0d words first=%0d,%0d,%0d expected 9,13,17",
                     words.size(), words.size() > 0 ? words[0] : -1,
                     words.size() > 1 ? words[1] : -1, words.size() > 2 ? words[2] : -1);
        end
    endtask

    task automatic test_decim_stall();
        logic [9:0] held;
        do_reset(1);
        en[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            res[1] = 10'($urandom);
            tick(1);
        end
        en[1] = 1'b0;
        n_cmp++;
        if (oc[1] !== 4'd6 || ov[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_count count=%0d valid=%b expected 6 and 1", oc[1], ov[1]);
        end
        held = od[1];
        for (int k = 0; k < 3; k++) begin
            tick(1);
            n_cmp++;
            if (od[1] !== held || od[1] !== 10'(mq[1][0])) begin
                n_fail++;
                $display("FAIL stall_hold data=%0d expected %0d", od[1], mq[1][0]);
            end
        end
        rdy[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (ov[1] !== (mc[1] > 0) || oc[1] !== 4'(mc[1]) || (mc[1] > 0 && od[1] !== 10'(mq[1][0]))) begin
                n_fail++;
                $display("FAIL stall_drain step=%0d valid=%b count=%0d data=%0d expected valid=%b count=%0d data=%0d",
                         k, ov[1], oc[1], od[1], mc[1] > 0, mc[1], mq[1][0]);
            end
            tick(1);
        end
    endtask

    task automatic test_overflow();
        do_reset(2);
        en[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            res[2] = 10'(99 + i);
            tick(2);
            n_cmp++;
            if (oc[2] !== 4'((i < 8) ? i : 8) || ovf[2] !== (i >= 9)) begin
                n_fail++;
                $display("FAIL overflow edge=%0d count=%0d ovf=%b expected count=%0d ovf=%b",
                         i, oc[2], ovf[2], (i < 8) ? i : 8, i >= 9);
            end
        end
        en[2]  = 1'b0;
        rdy[2] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            n_cmp++;
            if (ov[2] !== 1'b1 || od[2] !== 10'(100 + j)) begin
                n_fail++;
                $display("FAIL overflow_drain j=%0d valid=%b data=%0d expected 1 and %0d", j, ov[2], od[2], 100 + j);
            end
            tick(2);
        end
        n_cmp++;
        if (ov[2] !== 1'b0 || oc[2] !== 4'd0 || ovf[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky valid=%b count=%0d ovf=%b expected 0 0 1", ov[2], oc[2], ovf[2]);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset(2);
        en[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            res[2] = 10'($urandom);
            tick(2);
        end
        rdy[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            res[2] = 10'($urandom);
            tick(2);
            n_cmp++;
            if (oc[2] !== 4'd8 || ovf[2] !== 1'b0 || od[2] !== 10'(mq[2][0])) begin
                n_fail++;
                $display("FAIL full_pushpop k=%0d count=%0d ovf=%b data=%0d expected 8 0 %0d",
                         k, oc[2], ovf[2], od[2], mq[2][0]);
            end
        end
    endtask

    task automatic test_en_gating();
        logic       pat_en  [6] = '{1, 0, 1, 1, 0, 1};
        int         pat_res [6] = '{10, 20, 30, 40, 50, 60};
        do_reset(3);
        for (int k = 0; k < 6; k++) begin
            en[3]  = pat_en[k];
            res[3] = 10'(pat_res[k]);
            tick(3);
        end
        en[3] = 1'b0;
        n_cmp++;
        if (oc[3] !== 4'd2 || od[3] !== 10'd10) begin
            n_fail++;
            $display("FAIL en_gating count=%0d head=%0d expected 2 and 10", oc[3], od[3]);
        end
        rdy[3] = 1'b1;
        tick(3);
        n_cmp++;
        if (oc[3] !== 4'd1 || od[3] !== 10'd60) begin
            n_fail++;
            $display("FAIL en_gating_second count=%0d head=%0d expected 1 and 60", oc[3], od[3]);
        end
        tick(3);
    endtask

    task automatic test_async_reset();
        int guard;
        do_reset(0);
        en[0] = 1'b1;
        guard = 0;
        while (mc[0] < 5 && guard < 100) begin
            res[0] = 10'($urandom);
            tick(0);
            guard++;
        end
        n_cmp++;
        if (oc[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL async_prefill count=%0d expected 5 (cycles=%0d)", oc[0], guard);
        end
        #3;
        rst_n[0] = 1'b0;
        model_reset(0);
        #1;
        n_cmp++;
        if (ov[0] !== 1'b0 || oc[0] !== 4'd0 || ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset valid=%b count=%0d ovf=%b expected 0 0 0", ov[0], oc[0], ovf[0]);
        end
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        en[0]    = 1'b1;
        rdy[0]   = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            res[0] = 10'($urandom);
            tick(0);
            n_cmp++;
            if (oc[0] !== 4'(mc[0]) || ov[0] !== (k >= 9)) begin
                n_fail++;
                $display("FAIL async_rewarm edge=%0d count=%0d valid=%b expected %0d %b",
                         k, oc[0], ov[0], mc[0], k >= 9);
            end
        end
    endtask

    task automatic test_random();
        for (int id = 0; id < N; id++) begin
            do_reset(id);
            for (int k = 0; k < 200; k++) begin
                en[id]  = ($urandom_range(3) != 0);
                rdy[id] = ($urandom_range(2) == 0);
                res[id] = 10'($urandom);
                tick(id);
                n_cmp++;
                if (ov[id] !== (mc[id] > 0) || oc[id] !== 4'(mc[id]) || ovf[id] !== mov[id] ||
                    (mc[id] > 0 && od[id] !== 10'(mq[id][0]))) begin
                    n_fail++;
                    $display("FAIL random id=%0d k=%0d valid=%b count=%0d ovf=%b data=%0d expected %b %0d %b %0d",
                             id, k, ov[id], oc[id], ovf[id], od[id], mc[id] > 0, mc[id], mov[id], mq[id][0]);
                end
            end
            en[id]  = 1'b0;
            rdy[id] = 1'b0;
        end
    endtask

    initial begin
        for (int id = 0; id < N; id++) begin
            rst_n[id] = 1'b0;
            en[id]    = 1'b0;
            rdy[id]   = 1'b0;
            res[id]   = '0;
            model_reset(id);
        end
        #2;
        test_reset();
        test_warmup();
        test_decim_stall();
        test_overflow();
        test_full_pushpop();
        test_en_gating();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
